// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared mode, field and key-index constants for the clock's
//                front-panel controller, plus small field/mode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_pkg;

    // Operating modes of the clock front panel
    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;

    // Selectable time fields
    localparam logic [1:0] FIELD_SEC  = 2'd0;
    localparam logic [1:0] FIELD_MIN  = 2'd1;
    localparam logic [1:0] FIELD_HOUR = 2'd2;

    // Bit positions of the four keys inside the packed key vectors
    localparam int c_KEY_MODE = 0;
    localparam int c_KEY_SEL  = 1;
    localparam int c_KEY_UP   = 2;
    localparam int c_KEY_DOWN = 3;
    localparam int c_NUM_KEYS = 4;

    // One-hot select for the inc/dec buses: [0]=sec, [1]=min, [2]=hour
    function automatic logic [2:0] field_onehot(input logic [1:0] field);
        case (field)
            FIELD_MIN:  return 3'b010;
            FIELD_HOUR: return 3'b100;
            default:    return 3'b001;
        endcase
    endfunction

    // SEC -> MIN -> HOUR -> SEC
    function automatic logic [1:0] field_next(input logic [1:0] field);
        case (field)
            FIELD_SEC: return FIELD_MIN;
            FIELD_MIN: return FIELD_HOUR;
            default:   return FIELD_SEC;
        endcase
    endfunction

    // RUN -> SET_TIME -> SET_ALARM -> RUN
    function automatic logic [1:0] mode_next(input logic [1:0] mode);
        case (mode)
            MODE_RUN:      return MODE_SET_TIME;
            MODE_SET_TIME: return MODE_SET_ALARM;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchroniser, stability counter, debounced level and
//                one-cycle press pulse for one raw front-panel key.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);
    import clock_pkg::*;

    localparam int              c_CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYC - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic            r_armed;
    logic [1:0]      r_fill;
    logic [c_CW-1:0] r_cnt;

    // Bring the asynchronous key into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive mismatching samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    // A key held through reset must be seen released before it can press again;
    // the synchroniser needs two edges to carry a real sample, hence r_fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill  <= 2'd0;
            r_armed <= 1'b0;
        end else if (!r_armed) begin
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end else if (!r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_level & ~r_level_d & r_armed;

endmodule
`default_nettype wire

// File: rtl/clock_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_key_ctrl
//  Description : Front-panel controller: debounces four keys, runs the
//                RUN/SET_TIME/SET_ALARM mode FSM, selects the field, generates
//                one-hot inc/dec pulses with auto-repeat, and owns alarm enable
//                and alarm dismiss.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_key_ctrl #(
    parameter int DEBOUNCE_CYC  = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       alarming,
    output logic [1:0] mode,
    output logic [1:0] field,
    output logic [2:0] time_inc,
    output logic [2:0] time_dec,
    output logic [2:0] alarm_inc,
    output logic [2:0] alarm_dec,
    output logic       alarm_en,
    output logic       dis_alarm
);
    import clock_pkg::*;

    localparam int               c_RMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               c_RCW         = $clog2(c_RMAX + 1);
    localparam logic [c_RCW-1:0] c_DELAY_LAST  = c_RCW'(REPEAT_DELAY - 1);
    localparam logic [c_RCW-1:0] c_PERIOD_LAST = c_RCW'(REPEAT_PERIOD - 1);

    logic [c_NUM_KEYS-1:0] w_raw;
    logic [c_NUM_KEYS-1:0] w_level;
    logic [c_NUM_KEYS-1:0] w_press;

    assign w_raw = {key_down, key_up, key_sel, key_mode};

    generate
        for (genvar gi = 0; gi < c_NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_key_debounce (
                .clk    (clk),
                .rst    (rst),
                .i_key  (w_raw[gi]),
                .o_level(w_level[gi]),
                .o_press(w_press[gi])
            );
        end
    endgenerate

    logic [1:0]       r_mode;
    logic [1:0]       r_field;
    logic             r_rep_active;
    logic             r_rep_dn;
    logic             r_rep_phase;   // 0: waiting out the initial delay, 1: periodic
    logic [c_RCW-1:0] r_rep_cnt;
    logic [2:0]       r_time_inc;
    logic [2:0]       r_time_dec;
    logic [2:0]       r_alarm_inc;
    logic [2:0]       r_alarm_dec;
    logic             r_alarm_en;
    logic             r_dis_alarm;

    logic       w_press_mode;
    logic       w_press_sel;
    logic       w_press_up;
    logic       w_press_dn;
    logic       w_set_mode;
    logic       w_conflict;
    logic       w_hold;
    logic       w_rep_due;
    logic       w_pulse;
    logic       w_pulse_dn;
    logic       w_run_up;
    logic       w_run_dn;
    logic [2:0] w_oh;

    // Decide this cycle's key events; a mode press suppresses everything else
    always_comb begin
        w_press_mode = w_press[c_KEY_MODE];
        w_press_sel  = w_press[c_KEY_SEL];
        w_press_up   = w_press[c_KEY_UP];
        w_press_dn   = w_press[c_KEY_DOWN];
        w_set_mode   = (r_mode != MODE_RUN);
        w_conflict   = w_level[c_KEY_UP] & w_level[c_KEY_DOWN];
        w_hold       = r_rep_dn ? w_level[c_KEY_DOWN] : w_level[c_KEY_UP];
        w_rep_due    = r_rep_phase ? (r_rep_cnt == c_PERIOD_LAST) : (r_rep_cnt == c_DELAY_LAST);
        w_oh         = field_onehot(r_field);
        w_pulse      = 1'b0;
        w_pulse_dn   = 1'b0;
        if (!w_press_mode && w_set_mode && !w_conflict) begin
            if (w_press_up || w_press_dn) begin
                w_pulse    = 1'b1;
                w_pulse_dn = w_press_dn;
            end else if (r_rep_active && w_hold && w_rep_due) begin
                w_pulse    = 1'b1;
                w_pulse_dn = r_rep_dn;
            end
        end
        w_run_up = !w_press_mode && !w_set_mode && !w_conflict && w_press_up;
        w_run_dn = !w_press_mode && !w_set_mode && !w_conflict && w_press_dn && alarming;
    end

    // Mode FSM and field select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= MODE_RUN;
            r_field <= FIELD_SEC;
        end else if (w_press_mode) begin
            r_mode  <= mode_next(r_mode);
            r_field <= FIELD_SEC;
        end else if (w_press_sel && w_set_mode) begin
            r_field <= field_next(r_field);
        end
    end

    // Auto-repeat tracker: armed by a fresh up/down press, dropped on release,
    // up+down conflict, a mode press or leaving the SET modes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_active <= 1'b0;
            r_rep_dn     <= 1'b0;
            r_rep_phase  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_press_mode || w_conflict || !w_set_mode) begin
            r_rep_active <= 1'b0;
            r_rep_phase  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (w_press_up || w_press_dn) begin
            r_rep_active <= 1'b1;
            r_rep_dn     <= w_press_dn;
            r_rep_phase  <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (r_rep_active) begin
            if (!w_hold) begin
                r_rep_active <= 1'b0;
                r_rep_phase  <= 1'b0;
                r_rep_cnt    <= '0;
            end else if (w_rep_due) begin
                r_rep_phase <= 1'b1;
                r_rep_cnt   <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + c_RCW'(1);
            end
        end
    end

    // Registered pulse outputs and RUN-mode alarm controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time_inc  <= 3'b000;
            r_time_dec  <= 3'b000;
            r_alarm_inc <= 3'b000;
            r_alarm_dec <= 3'b000;
            r_alarm_en  <= 1'b0;
            r_dis_alarm <= 1'b0;
        end else begin
            r_time_inc  <= (w_pulse && !w_pulse_dn && (r_mode == MODE_SET_TIME))  ? w_oh : 3'b000;
            r_time_dec  <= (w_pulse &&  w_pulse_dn && (r_mode == MODE_SET_TIME))  ? w_oh : 3'b000;
            r_alarm_inc <= (w_pulse && !w_pulse_dn && (r_mode == MODE_SET_ALARM)) ? w_oh : 3'b000;
            r_alarm_dec <= (w_pulse &&  w_pulse_dn && (r_mode == MODE_SET_ALARM)) ? w_oh : 3'b000;
            r_dis_alarm <= w_run_dn;
            if (w_run_up) begin
                r_alarm_en <= ~r_alarm_en;
            end
        end
    end

    assign mode      = r_mode;
    assign field     = r_field;
    assign time_inc  = r_time_inc;
    assign time_dec  = r_time_dec;
    assign alarm_inc = r_alarm_inc;
    assign alarm_dec = r_alarm_dec;
    assign alarm_en  = r_alarm_en;
    assign dis_alarm = r_dis_alarm;

endmodule
`default_nettype wire

// File: tb/tb_clock_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_key_ctrl
//  Description : Self-checking bench for clock_key_ctrl: directed table,
//                multi-cycle corner sequences and random stimulus against a
//                cycle-level behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_key_ctrl;

    localparam int DC = 4;
    localparam int RD = 16;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0, key_sel = 1'b0, key_up = 1'b0, key_down = 1'b0;
    logic       alarming = 1'b0;
    logic [1:0] mode, field;
    logic [2:0] time_inc, time_dec, alarm_inc, alarm_dec;
    logic       alarm_en, dis_alarm;

    clock_key_ctrl #(
        .DEBOUNCE_CYC (DC),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_mode (key_mode),
        .key_sel  (key_sel),
        .key_up   (key_up),
        .key_down (key_down),
        .alarming (alarming),
        .mode     (mode),
        .field    (field),
        .time_inc (time_inc),
        .time_dec (time_dec),
        .alarm_inc(alarm_inc),
        .alarm_dec(alarm_dec),
        .alarm_en (alarm_en),
        .dis_alarm(dis_alarm)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       key_mode = v;
            1:       key_sel  = v;
            2:       key_up   = v;
            default: key_down = v;
        endcase
    endtask

    task automatic do_reset();
        key_mode = 0; key_sel = 0; key_up = 0; key_down = 0; alarming = 0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [11:0] all_pulses();
        return {time_inc, time_dec, alarm_inc, alarm_dec};
    endfunction

    // Hold key k for 'hold' edges, release, let it settle; gather what happened
    task automatic press_key(input int k, input int hold,
                             output logic [2:0] ti, output logic [2:0] td,
                             output logic [2:0] ai, output logic [2:0] ad, output int dis);
        ti = 0; td = 0; ai = 0; ad = 0; dis = 0;
        set_key(k, 1'b1);
        for (int i = 0; i < hold + 14; i++) begin
            if (i == hold) set_key(k, 1'b0);
            tick();
            ti |= time_inc; td |= time_dec; ai |= alarm_inc; ad |= alarm_dec;
            dis += int'(dis_alarm);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit         m_syncq[4][$];
    bit         m_win[4][$];
    bit         m_deb[4];
    bit         m_armed[4];
    bit         m_press[4];
    int         m_mode, m_field, m_rep, m_t0, m_edge;
    bit         m_en, e_dis;
    logic [2:0] e_ti, e_td, e_ai, e_ad;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_syncq[k].delete(); m_win[k].delete();
            m_deb[k] = 0; m_armed[k] = 0; m_press[k] = 0;
        end
        m_mode = 0; m_field = 0; m_rep = -1; m_t0 = 0; m_edge = 0; m_en = 0;
        e_dis = 0; e_ti = 0; e_td = 0; e_ai = 0; e_ad = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input bit alm);
        bit pulse, pdn, conflict, sync, real_s, flip;
        int pf;
        m_edge++;
        e_ti = 0; e_td = 0; e_ai = 0; e_ad = 0; e_dis = 0;
        pulse = 0; pdn = 0; pf = m_field;
        conflict = m_deb[2] && m_deb[3];
        if (m_press[0]) begin
            m_mode = (m_mode + 1) % 3; m_field = 0; m_rep = -1;
        end else begin
            if (m_press[1] && m_mode != 0) m_field = (m_field + 1) % 3;
            if (conflict) m_rep = -1;
            else if (m_mode == 0) begin
                if (m_press[2]) m_en = !m_en;
                if (m_press[3] && alm) e_dis = 1;
            end else if (m_press[2] || m_press[3]) begin
                pulse = 1; pdn = m_press[3]; m_rep = pdn ? 3 : 2; m_t0 = m_edge;
            end else if (m_rep >= 0) begin
                if (!m_deb[m_rep]) m_rep = -1;
                else if ((m_edge - m_t0) >= RD && ((m_edge - m_t0 - RD) % RP) == 0) begin
                    pulse = 1; pdn = (m_rep == 3);
                end
            end
            if (pulse) begin
                if (m_mode == 1 && !pdn) e_ti[pf] = 1'b1;
                if (m_mode == 1 &&  pdn) e_td[pf] = 1'b1;
                if (m_mode == 2 && !pdn) e_ai[pf] = 1'b1;
                if (m_mode == 2 &&  pdn) e_ad[pf] = 1'b1;
            end
        end
        // key conditioning: raw delayed two edges, level accepted after DC agreeing samples
        for (int k = 0; k < 4; k++) begin
            m_syncq[k].push_back(raw[k]);
            real_s = (m_syncq[k].size() > 2);
            sync   = real_s ? m_syncq[k].pop_front() : 1'b0;
            if (real_s && !sync) m_armed[k] = 1;
            m_win[k].push_back(sync);
            if (m_win[k].size() > DC) void'(m_win[k].pop_front());
            flip = (m_win[k].size() == DC);
            foreach (m_win[k][j]) if (m_win[k][j] == m_deb[k]) flip = 0;
            if (flip) m_deb[k] = !m_deb[k];
            m_press[k] = flip && m_deb[k] && m_armed[k];
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int         key;
        int         hold;
        bit         alm;
        logic [1:0] mode;
        logic [1:0] field;
        bit         en;
        logic [2:0] ti, td, ai, ad;
        int         dis;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [2:0] ti, td, ai, ad;
        int         dis, dur[5];
        bit         found, lvl[5];
        logic [11:0] acc;
        int         en_flips;

        tbl[0]  = '{2, 8, 0, 2'd0, 2'd0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[1]  = '{3, 8, 0, 2'd0, 2'd0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[2]  = '{3, 8, 1, 2'd0, 2'd0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 1};
        tbl[3]  = '{2, 8, 0, 2'd0, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[4]  = '{1, 8, 0, 2'd0, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[5]  = '{0, 8, 0, 2'd1, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[6]  = '{2, 8, 0, 2'd1, 2'd0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0};
        tbl[7]  = '{1, 8, 0, 2'd1, 2'd1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[8]  = '{3, 8, 0, 2'd1, 2'd1, 0, 3'b000, 3'b010, 3'b000, 3'b000, 0};
        tbl[9]  = '{0, 8, 0, 2'd2, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[10] = '{1, 8, 0, 2'd2, 2'd1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[11] = '{2, 8, 0, 2'd2, 2'd1, 0, 3'b000, 3'b000, 3'b010, 3'b000, 0};
        tbl[12] = '{1, 8, 0, 2'd2, 2'd2, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[13] = '{2, 8, 0, 2'd2, 2'd2, 0, 3'b000, 3'b000, 3'b100, 3'b000, 0};
        tbl[14] = '{1, 8, 0, 2'd2, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[15] = '{2, 8, 0, 2'd2, 2'd0, 0, 3'b000, 3'b000, 3'b001, 3'b000, 0};
        tbl[16] = '{3, 8, 0, 2'd2, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b001, 0};
        tbl[17] = '{0, 8, 0, 2'd0, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        tbl[18] = '{0, 3, 0, 2'd0, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0};

        // reset state while reset is held
        repeat (2) tick();
        check("reset_state", 32'({mode, field, all_pulses(), alarm_en, dis_alarm}), 32'd0);

        // debounce latency: edge 1 is the first edge sampling the key high
        do_reset();
        key_mode = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) check("latency_edge6", 32'(mode), 32'd0);
            if (e == 7) check("latency_edge7", 32'({mode, field}), 32'({2'd1, 2'd0}));
        end
        key_mode = 1'b0;
        repeat (12) tick();

        // directed table
        do_reset();
        for (int i = 0; i < 19; i++) begin
            alarming = tbl[i].alm;
            press_key(tbl[i].key, tbl[i].hold, ti, td, ai, ad, dis);
            alarming = 1'b0;
            check($sformatf("table_vec%0d", i),
                  32'({mode, field, alarm_en, ti, td, ai, ad, 4'(dis)}),
                  32'({tbl[i].mode, tbl[i].field, tbl[i].en, tbl[i].ti, tbl[i].td,
                       tbl[i].ai, tbl[i].ad, 4'(tbl[i].dis)}));
        end

        // auto-repeat in SET_TIME on MIN
        do_reset();
        press_key(0, 8, ti, td, ai, ad, dis);
        press_key(1, 8, ti, td, ai, ad, dis);
        key_up = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (time_inc != 3'b000) found = 1;
        end
        check("repeat_first_pulse", 32'({found, all_pulses()}), 32'({1'b1, 3'b010, 9'd0}));
        for (int off = 1; off <= 40; off++) begin
            tick();
            check($sformatf("repeat_t0+%0d", off), 32'(all_pulses()),
                  32'({((off == RD) || (off > RD && (off - RD) % RP == 0)) ? 3'b010 : 3'b000, 9'd0}));
        end
        key_up = 1'b0;
        repeat (DC + 2) tick();
        acc = 0;
        repeat (30) begin tick(); acc |= all_pulses(); end
        check("repeat_after_release", 32'(acc), 32'd0);

        // up+down together, then lone survivor
        key_up = 1'b1; key_down = 1'b1;
        acc = 0;
        repeat (40) begin tick(); acc |= all_pulses(); end
        key_down = 1'b0;
        repeat (30) begin tick(); acc |= all_pulses(); end
        key_up = 1'b0;
        repeat (12) begin tick(); acc |= all_pulses(); end
        check("conflict_no_pulse", 32'(acc), 32'd0);
        press_key(3, 8, ti, td, ai, ad, dis);
        check("after_conflict_press", 32'({ti, td, ai, ad}), 32'({3'b000, 3'b010, 6'd0}));

        // mode and up in the same cycle
        key_mode = 1'b1; key_up = 1'b1;
        acc = 0;
        repeat (30) begin tick(); acc |= all_pulses(); end
        key_mode = 1'b0; key_up = 1'b0;
        repeat (12) begin tick(); acc |= all_pulses(); end
        check("mode_beats_up", 32'({mode, field, acc}), 32'({2'd2, 2'd0, 12'd0}));

        // reset during an active repeat in SET_ALARM
        key_up = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (alarm_inc != 3'b000) found = 1;
        end
        check("rst_repeat_started", 32'(found), 32'd1);
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check("rst_async_clear", 32'({mode, field, all_pulses(), alarm_en, dis_alarm}), 32'd0);
        tick();
        rst = 1'b0;
        acc = 0; en_flips = 0;
        repeat (40) begin tick(); acc |= all_pulses(); en_flips += int'(alarm_en); end
        check("held_through_rst", 32'({acc, 8'(en_flips)}), 32'd0);
        key_up = 1'b0;
        repeat (12) tick();
        press_key(2, 8, ti, td, ai, ad, dis);
        check("repress_after_rst", 32'({mode, alarm_en}), 32'({2'd0, 1'b1}));

        // random stimulus against the reference model
        key_mode = 0; key_sel = 0; key_up = 0; key_down = 0; alarming = 0;
        rst = 1'b1;
        repeat (2) tick();
        model_reset();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin dur[k] = 5; lvl[k] = 0; end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int k = 0; k < 5; k++) begin
                if (dur[k] == 0) begin
                    lvl[k] = !lvl[k];
                    case (k)
                        0:       dur[k] = lvl[k] ? $urandom_range(1, 12) : $urandom_range(30, 150);
                        1:       dur[k] = lvl[k] ? $urandom_range(1, 10) : $urandom_range(10, 80);
                        4:       dur[k] = $urandom_range(10, 100);
                        default: dur[k] = lvl[k] ? $urandom_range(1, 60) : $urandom_range(5, 50);
                    endcase
                end else begin
                    dur[k]--;
                end
            end
            key_mode = lvl[0]; key_sel = lvl[1]; key_up = lvl[2]; key_down = lvl[3]; alarming = lvl[4];
            tick();
            model_edge({key_down, key_up, key_sel, key_mode}, alarming);
            check($sformatf("random_cyc%0d", cyc),
                  32'({mode, field, time_inc, time_dec, alarm_inc, alarm_dec, alarm_en, dis_alarm}),
                  32'({2'(m_mode), 2'(m_field), e_ti, e_td, e_ai, e_ad, m_en, e_dis}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
